fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a variable-latency instruction-memory req/ack interface.
- Presents {addr, instr, valid} for IF/ID to capture on the rising clock edge.
- Honours stall from the hazard unit and PC redirect from the branch logic in ID.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-low reset
start_i  input  1  begin fetching; sampled only in IDLE, then ignored (sticky)
stall_i  input  1  downstream cannot accept; hold current instruction
redirect_i  input  1  branch/jump taken in ID; squash and refetch
redirect_addr_i  input  32  new PC; bits [1:0] are forced to 0
imem_req_o  output  1  fetch request
imem_addr_o  output  32  fetch address; stable while req high and no ack
imem_ack_i  input  1  read data valid this cycle; ignored when req low
imem_rdata_i  input  32  instruction word
valid_o  output  1  addr_o/instr_o carry a real instruction this cycle
addr_o  output  32  PC of the presented instruction
instr_o  output  32  instruction word, or NOP when valid_o=0

Behaviour:
- Asynchronous reset (rst_i=0): pc=RESET_PC, req_addr=RESET_PC, state=IDLE, buffer cleared.
  - Outputs during reset: imem_req_o=0, valid_o=0, addr_o=0, instr_o=NOP (32'h0000_0013).
- Reset may assert in any state, including mid-request. Any later ack is ignored because req is low in IDLE.
- Registered state: pc (next fetch), req_addr (address of the outstanding request), buf_instr/buf_addr, state.
- Outputs are combinational from state, buffer and the current ack. Zero added latency: ack in cycle N is presented in cycle N.
- Priority: reset > redirect > stall > normal.
- IDLE:
  - All outputs are at their reset values.
  - start_i=1 at an edge -> FETCH with req_addr=pc.
- FETCH:
  - imem_req_o=1, imem_addr_o=req_addr.
  - No ack: valid_o=0, stay in FETCH.
  - ack, !stall_i, !redirect_i: valid_o=1, instr_o=imem_rdata_i, addr_o=req_addr. Then pc and req_addr <= req_addr+PC_STEP; stay in FETCH (back-to-back fetch).
  - ack, stall_i, !redirect_i: valid_o=1 with the same data. Capture into buf_*, pc <= req_addr+PC_STEP, go to HOLD.
  - redirect_i with ack: valid_o=0, data dropped. pc=req_addr=redirect target; stay in FETCH.
  - redirect_i without ack: valid_o=0, pc=target, go to DRAIN. req_addr is unchanged so the memory address stays stable.
- DRAIN:
  - imem_req_o=1, imem_addr_o=req_addr (the old address), valid_o=0.
  - On ack: data discarded, req_addr<=pc, go to FETCH.
  - A further redirect_i overwrites pc only.
- HOLD:
  - imem_req_o=0.
  - valid_o=1, instr_o=buf_instr, addr_o=buf_addr.
  - !stall_i -> FETCH with req_addr=pc.
  - redirect_i: valid_o=0, pc=req_addr=target, go to FETCH. Redirect overrides a simultaneous stall.
- PC arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 0).

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs fetch_cnt_o[31:0] and bubble_cnt_o[31:0].
  - fetch_cnt_o counts cycles with valid_o=1 and !stall_i (instructions delivered).
  - bubble_cnt_o counts non-IDLE cycles with valid_o=0.
  - Both counters wrap, and reset to 0 asynchronously.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package holds: state enum {IDLE, FETCH, DRAIN, HOLD}; NOP_INSTR=32'h0000_0013; RESET_PC default; PC_STEP.
- One natural sub-module, fetch_perf_cnt, holds both counters and is instantiated only under FETCH_PERF_EN.
- The PC/state logic stays in fetch_unit.

Test Plan:
1. Reset: hold rst_i=0 with random inputs -> imem_req_o=0, valid_o=0, instr_o=32'h13. Release reset with start_i=0 for 5 cycles -> no request.
2. Streaming: pulse start_i, ack every cycle with rdata=addr^32'hA5A5_0000 -> valid_o on consecutive cycles with addr_o=0,4,8,12 and instr_o matching.
3. Stall: stall_i=1 in the ack cycle for addr 8, held 3 cycles -> addr_o=8 held with imem_req_o=0. After release, the next request is for addr 12.
4. Redirect mid-request: req for 0x10 outstanding, redirect_i to 0x43 with no ack, ack 2 cycles later -> imem_addr_o stays 0x10 until that ack, data dropped, next request 0x40, valid_o=0 throughout.
5. Redirect and stall together in HOLD, target 0x100 -> valid_o=0, next request 0x100. Separately, pc=0xFFFF_FFFC then ack -> next request 0x0.
6. With FETCH_PERF_EN, replay scenario 3 -> fetch_cnt_o=4 after 4 delivered instructions; bubble_cnt_o equals the counted ack-less non-IDLE cycles.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction-fetch stage:
//   - fetch_state_e : fetch controller states (IDLE, FETCH, DRAIN, HOLD)
//   - NOP_INSTR     : instruction presented whenever no valid instruction exists
//   - DEFAULT_RESET_PC / DEFAULT_PC_STEP : parameter defaults for fetch_unit
//   - align_word()  : forces a byte address onto a 32-bit word boundary
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

  // Redirect targets may carry garbage in the low two bits; fetches are
  // always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// ---------------------------------------------------------------------------
// fetch_perf_cnt
// Performance counters for the fetch stage. Only built when FETCH_PERF_EN is
// defined; otherwise this file contributes no module.
// Ports:
//   clk_i         : clock, rising edge
//   rst_i         : asynchronous, active-low reset (counters clear to 0)
//   fetch_evt_i   : an instruction was handed downstream this cycle
//   bubble_evt_i  : the stage was active but presented no instruction
//   fetch_cnt_o   : wrapping count of fetch events
//   bubble_cnt_o  : wrapping count of bubble events
// ---------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
module fetch_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_evt_i,
  input  logic        bubble_evt_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Both counters simply wrap at 2^32.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (fetch_evt_i)  fetch_cnt_d  = fetch_cnt_q + 32'd1;
    if (bubble_evt_i) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule
`endif

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
// drives a variable-latency req/ack instruction memory and presents
// {addr_o, instr_o, valid_o} combinationally so that an ack in cycle N is
// visible to IF/ID in cycle N.
//
// Optional feature macro: FETCH_PERF_EN adds fetch_cnt_o / bubble_cnt_o.
//
// Ports:
//   clk_i, rst_i (async active-low)
//   start_i                        : leave IDLE (only looked at in IDLE)
//   stall_i                        : downstream holds, keep instruction
//   redirect_i, redirect_addr_i    : squash and refetch from new target
//   imem_req_o, imem_addr_o        : memory request, address stable until ack
//   imem_ack_i, imem_rdata_i       : memory response
//   valid_o, addr_o, instr_o       : instruction presented to IF/ID
//   fetch_cnt_o, bubble_cnt_o      : performance counters (FETCH_PERF_EN)
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] addr_o,
  output logic [31:0] instr_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [31:0]  buf_addr_q, buf_addr_d;

  logic [31:0]  target;
  logic [31:0]  seq_addr;

  assign target   = align_word(redirect_addr_i);
  assign seq_addr = req_addr_q + PC_STEP;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      buf_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_addr_q  <= buf_addr_d;
    end
  end

  // Next-state logic. Redirect outranks stall everywhere. While a request is
  // outstanding its address must not move, so a redirect without ack only
  // updates pc and lets DRAIN swallow the stale response.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    buf_instr_d = buf_instr_q;
    buf_addr_d  = buf_addr_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = FETCH;
          req_addr_d = pc_q;
        end
      end

      FETCH: begin
        if (redirect_i) begin
          pc_d = target;
          if (imem_ack_i) req_addr_d = target;
          else            state_d    = DRAIN;
        end else if (imem_ack_i) begin
          pc_d = seq_addr;
          if (stall_i) begin
            buf_instr_d = imem_rdata_i;
            buf_addr_d  = req_addr_q;
            state_d     = HOLD;
          end else begin
            req_addr_d  = seq_addr;
          end
        end
      end

      DRAIN: begin
        // A redirect arriving together with the ack takes effect at once so
        // the newest target is the one fetched.
        if (redirect_i) pc_d = target;
        if (imem_ack_i) begin
          req_addr_d = redirect_i ? target : pc_q;
          state_d    = FETCH;
        end
      end

      HOLD: begin
        if (redirect_i) begin
          pc_d       = target;
          req_addr_d = target;
          state_d    = FETCH;
        end else if (!stall_i) begin
          req_addr_d = pc_q;
          state_d    = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Output logic; purely combinational from state, buffer and current ack.
  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = req_addr_q;
    valid_o     = 1'b0;
    addr_o      = '0;
    instr_o     = NOP_INSTR;

    unique case (state_q)
      IDLE: ;
      FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i && !redirect_i) begin
          valid_o = 1'b1;
          addr_o  = req_addr_q;
          instr_o = imem_rdata_i;
        end
      end
      DRAIN: imem_req_o = 1'b1;
      HOLD: begin
        if (!redirect_i) begin
          valid_o = 1'b1;
          addr_o  = buf_addr_q;
          instr_o = buf_instr_q;
        end
      end
      default: ;
    endcase
  end

`ifdef FETCH_PERF_EN
  fetch_perf_cnt u_perf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fetch_evt_i  (valid_o && !stall_i),
    .bubble_evt_i ((state_q != IDLE) && !valid_o),
    .fetch_cnt_o  (fetch_cnt_o),
    .bubble_cnt_o (bubble_cnt_o)
  );
`endif

endmodule
